// File: rtl/adc_serial_sender.sv
// rtl/adc_serial_sender.sv - FIFO-buffered 16-bit serial word transmitter for ADC samples
module adc_serial_sender #(
  parameter int         FIFO_AW    = 4,
  parameter int         GAP_CYCLES = 0,
  parameter logic [5:0] HDR_TAG    = 6'h3F
) (
  input  logic             rcv_clk,
  input  logic             rst_n,
  input  logic             i_enable,
  input  logic             i_frame_start,
  input  logic [9:0]       i_smp_data,
  input  logic             i_smp_vld,
  output logic             o_smp_rdy,
  output logic             o_d,
  output logic             o_fs,
  output logic             o_busy,
  output logic [FIFO_AW:0] o_level
);

  localparam int               DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [7:0]       GAP_LEN  = 8'(GAP_CYCLES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [9:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;

  logic [1:0]  state;
  logic [14:0] sh;
  logic [3:0]  bitcnt;
  logic [7:0]  gapcnt;
  logic [5:0]  tag;
  logic        hdr_pend;

  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        word_done;
  logic        start;
  logic        hdr_load;
  logic [15:0] next_word;

  assign full      = (count == FULL_LVL);
  assign empty     = (count == '0);
  assign o_smp_rdy = rst_n & ~full;
  assign o_level   = count;
  assign push      = i_smp_vld & o_smp_rdy;

  // A new word may begin when idle, on the bit-0 cycle (no gap), or on the last gap cycle
  always_comb begin
    word_done = 1'b0;
    case (state)
      S_IDLE:  word_done = 1'b1;
      S_SHIFT: word_done = (bitcnt == 4'd0) && (GAP_CYCLES == 0);
      S_GAP:   word_done = (gapcnt == 8'd1);
      default: word_done = 1'b1;
    endcase
  end

  assign start     = word_done & i_enable & (hdr_pend | ~empty);
  assign hdr_load  = start & hdr_pend;
  assign pop       = start & ~hdr_pend;
  assign next_word = hdr_pend ? {HDR_TAG, 10'h000} : {tag, mem[rd_ptr]};

  // Sample storage; contents need no reset because occupancy tracks validity
  always_ff @(posedge rcv_clk) begin
    if (push) mem[wr_ptr] <= i_smp_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge rcv_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Word tag sequence and header request latch; a pulse coinciding with a header load re-arms it
  always_ff @(posedge rcv_clk or negedge rst_n) begin
    if (!rst_n) begin
      tag      <= '0;
      hdr_pend <= 1'b0;
    end else begin
      hdr_pend <= i_frame_start | (hdr_pend & ~hdr_load);
      if (hdr_load)
        tag <= '0;
      else if (pop)
        tag <= (tag == HDR_TAG - 6'd1) ? 6'd0 : tag + 6'd1;
    end
  end

  // Serializer: bit 15 goes out on the load edge with fs, then one lower bit per edge
  always_ff @(posedge rcv_clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      sh     <= '0;
      bitcnt <= '0;
      gapcnt <= '0;
      o_d    <= 1'b0;
      o_fs   <= 1'b0;
      o_busy <= 1'b0;
    end else begin
      o_fs <= 1'b0;
      if (start) begin
        state  <= S_SHIFT;
        sh     <= next_word[14:0];
        bitcnt <= 4'd15;
        o_d    <= next_word[15];
        o_fs   <= 1'b1;
        o_busy <= 1'b1;
      end else begin
        case (state)
          S_SHIFT: begin
            if (bitcnt != 4'd0) begin
              o_d    <= sh[14];
              sh     <= {sh[13:0], 1'b0};
              bitcnt <= bitcnt - 4'd1;
            end else if (GAP_CYCLES > 0) begin
              state  <= S_GAP;
              gapcnt <= GAP_LEN;
              o_d    <= 1'b0;
            end else begin
              state  <= S_IDLE;
              o_d    <= 1'b0;
              o_busy <= 1'b0;
            end
          end
          S_GAP: begin
            if (gapcnt == 8'd1) begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end else begin
              gapcnt <= gapcnt - 8'd1;
            end
          end
          default: begin
            state  <= S_IDLE;
            o_d    <= 1'b0;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_serial_sender.sv
// tb/tb_adc_serial_sender.sv - self-checking bench for adc_serial_sender (GAP 0 and GAP 3 lanes)
module tb_adc_serial_sender;

  logic       rcv_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       en      = 1'b0;
  logic       fstart  = 1'b0;
  logic       vld     = 1'b0;
  logic [9:0] data    = '0;

  logic       rdy_o  [2];
  logic       d_o    [2];
  logic       fs_o   [2];
  logic       busy_o [2];
  logic [4:0] lvl_o  [2];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [15:0] exp_w[$];
  int          etag = 0;

  always #5 rcv_clk = ~rcv_clk;
  always @(posedge rcv_clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int GAP = 3 * g;
    logic [9:0]  q[$];
    logic [15:0] cap[$];
    int          fs_t[$];
    int          left = 0;
    int          pos = 0;
    int          tagm = 0;
    int          nb = 0;
    logic        hdr = 1'b0;
    logic [15:0] w = '0;
    logic [15:0] sr = '0;
    logic        ed, efs, ebusy, erdy;
    logic [4:0]  elvl;

    adc_serial_sender #(.FIFO_AW(4), .GAP_CYCLES(GAP), .HDR_TAG(6'h3F)) dut (
      .rcv_clk(rcv_clk), .rst_n(rst_n), .i_enable(en), .i_frame_start(fstart),
      .i_smp_data(data), .i_smp_vld(vld), .o_smp_rdy(rdy_o[g]), .o_d(d_o[g]),
      .o_fs(fs_o[g]), .o_busy(busy_o[g]), .o_level(lvl_o[g]));

    // Reference: a word occupies 16+GAP cycles; the next may start on its final cycle
    always @(posedge rcv_clk or negedge rst_n) begin
      bit acc, ld, hl;
      if (!rst_n) begin
        q.delete(); left = 0; pos = 0; tagm = 0; hdr = 1'b0; w = '0;
      end else begin
        acc = vld && (q.size() < 16);
        ld  = en && (left <= 1) && (hdr || q.size() > 0);
        hl  = ld && hdr;
        if (ld) begin
          if (hl) begin
            w = 16'hFC00; tagm = 0;
          end else begin
            w = {tagm[5:0], q.pop_front()}; tagm = (tagm + 1) % 63;
          end
          left = 16 + GAP; pos = 0;
        end else if (left > 0) begin
          left--; pos++;
        end
        hdr = fstart || (hdr && !hl);
        if (acc) q.push_back(data);
      end
    end

    // Per-cycle comparison against the reference plus word capture
    always @(negedge rcv_clk) begin
      ebusy = rst_n && (left > 0);
      efs   = ebusy && (pos == 0);
      ed    = (ebusy && pos < 16) ? w[15 - pos] : 1'b0;
      elvl  = 5'(q.size());
      erdy  = rst_n && (q.size() < 16);
      chk($sformatf("lane%0d o_d @%0d", g, cyc), 32'(d_o[g]), 32'(ed));
      chk($sformatf("lane%0d o_fs @%0d", g, cyc), 32'(fs_o[g]), 32'(efs));
      chk($sformatf("lane%0d o_busy @%0d", g, cyc), 32'(busy_o[g]), 32'(ebusy));
      chk($sformatf("lane%0d o_level @%0d", g, cyc), 32'(lvl_o[g]), 32'(elvl));
      chk($sformatf("lane%0d o_smp_rdy @%0d", g, cyc), 32'(rdy_o[g]), 32'(erdy));
      if (!rst_n) nb = 0;
      else if (fs_o[g] === 1'b1) begin
        sr = {15'd0, d_o[g]}; nb = 1; fs_t.push_back(cyc);
      end else if (nb > 0) begin
        sr = {sr[14:0], d_o[g]}; nb++;
      end
      if (nb == 16) begin
        cap.push_back(sr); nb = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge rcv_clk);
  endtask

  task automatic clear_caps();
    lane[0].cap.delete(); lane[1].cap.delete();
    lane[0].fs_t.delete(); lane[1].fs_t.delete();
    exp_w.delete();
  endtask

  task automatic push(input logic [9:0] v);
    int t = 0;
    while (!(lane[0].q.size() < 16 && lane[1].q.size() < 16) && t < 2000) begin
      @(negedge rcv_clk); t++;
    end
    if (t >= 2000) begin
      n_chk++; n_fail++;
      $display("FAIL push_wait: no space after %0d cycles, required space", t);
    end
    vld = 1'b1; data = v;
    @(negedge rcv_clk);
    vld = 1'b0;
  endtask

  task automatic expect_data(input logic [9:0] v);
    exp_w.push_back({etag[5:0], v});
    etag = (etag + 1) % 63;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((lane[0].left > 0 || lane[1].left > 0 || lane[0].q.size() != 0 ||
            lane[1].q.size() != 0 || lane[0].hdr || lane[1].hdr) && t < 3000) begin
      @(negedge rcv_clk); t++;
    end
    n_chk++;
    if (t >= 3000) begin
      n_fail++;
      $display("FAIL wait_idle: still active after %0d cycles, required idle", t);
    end
    tick(2);
  endtask

  task automatic check_words(input string nm);
    chk({nm, " lane0 count"}, 32'(lane[0].cap.size()), 32'(exp_w.size()));
    chk({nm, " lane1 count"}, 32'(lane[1].cap.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++) begin
      chk($sformatf("%s lane0 word%0d", nm, i),
          (i < lane[0].cap.size()) ? 32'(lane[0].cap[i]) : 32'hDEAD, 32'(exp_w[i]));
      chk($sformatf("%s lane1 word%0d", nm, i),
          (i < lane[1].cap.size()) ? 32'(lane[1].cap[i]) : 32'hDEAD, 32'(exp_w[i]));
    end
    clear_caps();
  endtask

  typedef struct {
    logic       vld;
    logic [9:0] data;
    logic       en;
    logic       d;
    logic       fs;
    logic       busy;
    logic [4:0] lvl;
    logic       rdy;
  } vec_t;

  vec_t        tbl[18];
  logic [15:0] wv;
  logic [9:0]  smp[$];

  initial begin
    // single-sample vector table: record i inputs before edge i, expectations after it
    wv = 16'h02A5;
    tbl[0] = '{vld: 1'b1, data: 10'h2A5, en: 1'b1, d: 1'b0, fs: 1'b0, busy: 1'b0, lvl: 5'd1, rdy: 1'b1};
    for (int i = 1; i <= 16; i++)
      tbl[i] = '{vld: 1'b0, data: 10'h000, en: 1'b1, d: wv[16 - i], fs: (i == 1), busy: 1'b1, lvl: 5'd0, rdy: 1'b1};
    tbl[17] = '{vld: 1'b0, data: 10'h000, en: 1'b1, d: 1'b0, fs: 1'b0, busy: 1'b0, lvl: 5'd0, rdy: 1'b1};

    // reset state
    tick(3);
    chk("reset o_smp_rdy", 32'(rdy_o[0]), 0);
    chk("reset o_level", 32'(lvl_o[0]), 0);
    chk("reset o_busy", 32'(busy_o[0]), 0);
    chk("reset o_fs", 32'(fs_o[0]), 0);
    rst_n = 1'b1;
    tick(2);
    chk("post-reset o_smp_rdy", 32'(rdy_o[0]), 1);

    for (int i = 0; i < 18; i++) begin
      vld = tbl[i].vld; data = tbl[i].data; en = tbl[i].en;
      @(negedge rcv_clk);
      chk($sformatf("tbl%0d o_d", i), 32'(d_o[0]), 32'(tbl[i].d));
      chk($sformatf("tbl%0d o_fs", i), 32'(fs_o[0]), 32'(tbl[i].fs));
      chk($sformatf("tbl%0d o_busy", i), 32'(busy_o[0]), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d o_level", i), 32'(lvl_o[0]), 32'(tbl[i].lvl));
      chk($sformatf("tbl%0d o_smp_rdy", i), 32'(rdy_o[0]), 32'(tbl[i].rdy));
    end
    vld = 1'b0;
    etag = 1;
    wait_idle();
    clear_caps();

    // back-to-back burst of 20: continuous words, fs every 16 (lane0) / 19 (lane1)
    for (int i = 1; i <= 20; i++) begin
      push(10'(i)); expect_data(10'(i));
    end
    wait_idle();
    chk("burst lane0 fs count", 32'(lane[0].fs_t.size()), 20);
    chk("burst lane1 fs count", 32'(lane[1].fs_t.size()), 20);
    for (int k = 1; k < 20; k++) begin
      chk($sformatf("burst lane0 fs spacing%0d", k),
          (k < lane[0].fs_t.size()) ? 32'(lane[0].fs_t[k] - lane[0].fs_t[k-1]) : 0, 16);
      chk($sformatf("burst lane1 fs spacing%0d", k),
          (k < lane[1].fs_t.size()) ? 32'(lane[1].fs_t[k] - lane[1].fs_t[k-1]) : 0, 19);
    end
    check_words("burst");

    // disabled: 17 offered, 16 accepted, nothing transmitted; then drain in order
    en = 1'b0;
    smp.delete();
    for (int i = 0; i < 17; i++) begin
      vld = 1'b1; data = 10'($urandom); smp.push_back(data);
      @(negedge rcv_clk);
    end
    vld = 1'b0;
    tick(3);
    chk("disabled lane0 level", 32'(lvl_o[0]), 16);
    chk("disabled lane1 level", 32'(lvl_o[1]), 16);
    chk("disabled lane0 rdy", 32'(rdy_o[0]), 0);
    chk("disabled lane0 o_d", 32'(d_o[0]), 0);
    chk("disabled lane0 busy", 32'(busy_o[0]), 0);
    for (int i = 0; i < 16; i++) expect_data(smp[i]);
    en = 1'b1;
    @(negedge rcv_clk);
    chk("enable lane0 fs", 32'(fs_o[0]), 1);
    chk("enable lane0 rdy back", 32'(rdy_o[0]), 1);
    chk("enable lane0 level", 32'(lvl_o[0]), 15);
    wait_idle();
    check_words("drain");

    // two header requests during a word: exactly one header, then tags restart at 0
    push(10'h111); push(10'h222); push(10'h333);
    tick(3);
    fstart = 1'b1; tick(1); fstart = 1'b0;
    tick(2);
    fstart = 1'b1; tick(1); fstart = 1'b0;
    expect_data(10'h111);
    exp_w.push_back(16'hFC00);
    etag = 0;
    expect_data(10'h222);
    expect_data(10'h333);
    wait_idle();
    check_words("header");

    // asynchronous reset in the middle of a word
    push(10'h155); push(10'h0AA);
    tick(5);
    chk("pre-reset lane0 busy", 32'(busy_o[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async lane0 o_d", 32'(d_o[0]), 0);
    chk("async lane0 o_fs", 32'(fs_o[0]), 0);
    chk("async lane0 o_busy", 32'(busy_o[0]), 0);
    chk("async lane0 o_level", 32'(lvl_o[0]), 0);
    chk("async lane0 o_smp_rdy", 32'(rdy_o[0]), 0);
    chk("async lane1 o_busy", 32'(busy_o[1]), 0);
    tick(2);
    rst_n = 1'b1;
    etag = 0;
    clear_caps();
    tick(1);

    // 64 words after reset: tags 0..62 then 0, never 3F
    for (int i = 0; i < 64; i++) begin
      push(10'(i * 7 + 3)); expect_data(10'(i * 7 + 3));
    end
    wait_idle();
    chk("wrap tag62", (lane[0].cap.size() > 62) ? 32'(lane[0].cap[62][15:10]) : 32'hFF, 62);
    chk("wrap tag0", (lane[0].cap.size() > 63) ? 32'(lane[0].cap[63][15:10]) : 32'hFF, 0);
    check_words("wrap");

    // randomized traffic, checked cycle by cycle against the reference
    for (int i = 0; i < 800; i++) begin
      en     = ($urandom_range(0, 7) != 0);
      vld    = $urandom_range(0, 1) != 0;
      data   = 10'($urandom);
      fstart = ($urandom_range(0, 40) == 0);
      @(negedge rcv_clk);
    end
    en = 1'b1; vld = 1'b0; fstart = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_serial_sender.md
Name: adc_serial_sender

Overview:
- Transmit-side counterpart of the serial ADC receive path.
- Accepts 10-bit ADC samples on a valid/ready stream and buffers them in a small FIFO.
- Serializes each sample as a 16-bit word, MSB first, on a 1-bit data line, with a frame-sync strobe marking bit 15 of each word.
- Inserts a header word on request so the far end can realign its scan buffer.

Parameters:
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW words (16).
- GAP_CYCLES, 0, idle cycles between consecutive words (0..255).
- HDR_TAG, 6'h3F, tag value reserved for header words; data tags never take this value.

Ports:
- rcv_clk  in  1  serial bit clock; all logic in this domain.
- rst_n  in  1  asynchronous, active-low reset.
- i_enable  in  1  1 = start new words; 0 = finish current word, then idle.
- i_frame_start  in  1  single-cycle pulse requesting a header word.
- i_smp_data  in  10  ADC sample.
- i_smp_vld  in  1  sample valid.
- o_smp_rdy  out  1  FIFO can accept a sample.
- o_d  out  1  serial data, registered.
- o_fs  out  1  frame sync; high during the bit-15 cycle of every word; registered.
- o_busy  out  1  high while a word or its gap is in progress.
- o_level  out  FIFO_AW+1  FIFO occupancy.

Behaviour:
- Reset: o_d=0, o_fs=0, o_busy=0, o_smp_rdy=0, o_level=0; FIFO empty; tag=0; header-pending=0; state IDLE. Reset is async, so a mid-word reset clears outputs immediately and the partial word is lost.
- o_smp_rdy = ~full, and is 0 while in reset. A sample is written when i_smp_vld & o_smp_rdy. No bypass: when full, a simultaneous read does not raise rdy in that cycle. Simultaneous write and read leaves o_level unchanged.
- Word format:
  - Data word = {tag[5:0], sample[9:0]}.
  - Header word = {HDR_TAG, 10'h000}.
- Tag counter:
  - Increments after each data word is loaded.
  - Wraps from HDR_TAG-1 to 0, skipping HDR_TAG (default sequence 0..62, 0).
  - Reset to 0 when a header word is loaded.
- Header request:
  - i_frame_start sets header-pending.
  - Header-pending is cleared when the header is loaded.
  - Multiple pulses before the load produce one header.
  - A pulse in the same cycle as the header load leaves pending set, so a second header follows.
  - FIFO contents are not flushed.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: if i_enable & (header-pending | ~empty), then on that edge:
    - load shift register; header has priority over FIFO;
    - drive o_d = word[15], o_fs = 1, o_busy = 1;
    - bitcnt = 15; pop FIFO if a data word was loaded;
    - go to SHIFT.
    Otherwise o_d=0, o_fs=0, o_busy=0.
  - SHIFT: each edge outputs the next lower bit with o_fs=0 and decrements bitcnt. After the bit-0 cycle:
    - if GAP_CYCLES>0, go to GAP (o_d=0, o_fs=0, o_busy=1, gapcnt=GAP_CYCLES);
    - else apply the IDLE load condition directly: back-to-back load, or IDLE.
  - GAP: decrement gapcnt; on the last gap cycle apply the IDLE load condition.
- Word period = 16 + GAP_CYCLES cycles. Continuous fs spacing holds whenever a source is available.
- Latency: a sample accepted at edge k into an empty FIFO while idle and enabled produces o_fs=1 with bit 15 after edge k+1.
- i_enable low mid-word: the current word and its gap complete, then the block holds IDLE. Samples are still accepted until the FIFO is full.
- Header-pending ignores i_enable for setting, but is only serviced when enabled.

Test Plan:
- Reset, GAP=0, push 10'h2A5 → o_fs high one cycle after accept; 16 bits serialize 16'h02A5 MSB first; o_busy high exactly 16 cycles, then 0.
- Burst of 20 samples 10'h001..10'h014, GAP=0 → fs every 16 cycles with no idle; tags 0..19 in bits 15:10.
- GAP=3 → fs spacing 19 cycles; o_d=0 and o_busy=1 during gaps.
- i_enable=0, offer 17 samples → 16 accepted, rdy drops, o_level=16, o_d stays 0. Raise enable → drains in order; rdy returns one cycle after the first pop.
- Push 64 samples → tags 0..62, then 0 (6'h3F never appears on data words).
- Two i_frame_start pulses mid-word with FIFO non-empty → current word completes, exactly one 16'hFC00 header follows, then the next data word has tag 0.
- Assert rst_n low mid-SHIFT → o_d, o_fs, o_busy, o_level, o_smp_rdy go to 0 immediately. After release, the first word has tag 0.
